pixel_fetch: RTL and testbench

PIXEL_FETCH -- requirements
Module: pixel_fetch

---
 rtl/vga_pkg.sv | 15 +
 rtl/line_buffer.sv | 33 +++
 rtl/pixel_fetch.sv | 225 ++++++++++++++++++++++
 tb/tb_pixel_fetch.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Types and constants shared by the 1 bpp pixel fetch path.
// Fetch state encodings double as plain constants for older tooling.
package vga_pkg;
   localparam int RGB_W = 6;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      REQ  = ST_REQ,
      DONE = ST_DONE
   } fetch_state_t;
endpackage

// File: rtl/line_buffer.sv
// Two banks of one logical line each, held in flops.
// One write port for the fetch side and one combinational read port for display.
module line_buffer #(
   parameter int WORDS   = 25,
   parameter int WORD_AW = 5
) (
   input  logic               clk,
   input  logic               wr_en,
   input  logic               wr_bank,
   input  logic [WORD_AW-1:0] wr_word,
   input  logic [15:0]        wr_data,
   input  logic               rd_bank,
   input  logic [4:0]         rd_word,
   output logic [15:0]        rd_data
);
   logic [1:0][15:0] bank_rd;

   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [15:0] mem_q [WORDS];

      always_ff @(posedge clk) begin
         if (wr_en && (wr_bank == 1'(gi)) && (32'(wr_word) < WORDS)) begin
            mem_q[wr_word] <= wr_data;
         end
      end

      // Words past the end of the row read as zero; they are never displayed.
      assign bank_rd[gi] = (32'(rd_word) < WORDS) ? mem_q[rd_word] : 16'h0000;
   end

   assign rd_data = bank_rd[rd_bank];
endmodule

// File: rtl/pixel_fetch.sv
// Fetches one 1 bpp logical line per pair of physical lines into a ping-pong
// line buffer and expands it to RGB222 with 2x2 pixel doubling.
module pixel_fetch import vga_pkg::*; #(
   parameter int WORDS_PER_ROW = 25,
   parameter int LINES         = 300,
   parameter int ADDR_W        = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [9:0]        x_pos,
   input  logic              blank,
   input  logic              hsync,
   input  logic              vsync,
   input  logic              vsync_pulse,
   input  logic [ADDR_W-1:0] fb_base,
   input  logic [RGB_W-1:0]  fg,
   input  logic [RGB_W-1:0]  bg,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [15:0]       mem_data,
   output logic [RGB_W-1:0]  rgb,
   output logic              hsync_o,
   output logic              vsync_o,
   output logic              underrun
);
   localparam int WORD_AW = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
   localparam int LINE_W  = $clog2(LINES + 1);

   fetch_state_t        state_q, state_d;
   logic [WORD_AW-1:0]  word_q, word_d;
   logic                mem_req_q, mem_req_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                discard_q, discard_d;
   logic                pend_q, pend_d;
   logic [LINE_W-1:0]   pend_line_q, pend_line_d;
   logic                underrun_q, underrun_d;
   logic [9:0]          phys_line_q, phys_line_d;
   logic                blank_prev_q;
   logic                rd_bank_q, rd_bank_d;
   logic [1:0]          valid_q, valid_d;
   logic [RGB_W-1:0]    rgb_q, rgb_d;
   logic                hsync_q, vsync_q;

   logic                blank_fall, swap, frame_evt, ack, last_word, wr_bank, wr_en;
   logic                start_req, launch, launch_go;
   logic [LINE_W-1:0]   disp_line, next_line, start_line, launch_line;
   logic [15:0]         lb_rd_data;
   logic [3:0]          bit_idx;
   logic                unused_bits;

   assign unused_bits = x_pos[0];

   function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [LINE_W-1:0] line);
      return base + ADDR_W'(32'(line) * 32'(WORDS_PER_ROW));
   endfunction

   assign blank_fall = blank_prev_q & ~blank;
   assign swap       = blank_fall & ~phys_line_q[0] & ~vsync_pulse;
   assign frame_evt  = swap | vsync_pulse;
   assign ack        = mem_req_q & mem_ack;
   assign last_word  = (32'(word_q) == WORDS_PER_ROW - 1);
   assign wr_bank    = ~rd_bank_q;
   assign disp_line  = LINE_W'(phys_line_q >> 1);
   assign next_line  = disp_line + LINE_W'(1);
   assign start_req  = vsync_pulse | (swap & (32'(next_line) < LINES));
   assign start_line = vsync_pulse ? '0 : next_line;

   always_comb begin
      phys_line_d = phys_line_q;
      if (vsync_pulse) begin
         phys_line_d = '0;
      end else if (blank_fall) begin
         phys_line_d = phys_line_q + 10'd1;
      end
   end

   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      discard_d   = discard_q;
      pend_d      = pend_q;
      pend_line_d = pend_line_q;
      underrun_d  = underrun_q;
      valid_d     = valid_q;
      wr_en       = 1'b0;
      launch      = 1'b0;
      launch_go   = 1'b0;
      launch_line = '0;
      rd_bank_d   = swap ? ~rd_bank_q : rd_bank_q;

      // The bank leaving display becomes the fetch target and starts empty.
      if (vsync_pulse) begin
         valid_d = 2'b00;
      end else if (swap) begin
         valid_d[rd_bank_q] = 1'b0;
      end

      case (state_q)
         REQ: begin
            if (frame_evt) begin
               underrun_d = 1'b1;
               if (ack) begin
                  discard_d   = 1'b0;
                  launch      = 1'b1;
                  launch_go   = start_req;
                  launch_line = start_line;
               end else begin
                  discard_d   = 1'b1;
                  pend_d      = start_req;
                  pend_line_d = start_line;
               end
            end else if (ack) begin
               if (discard_q) begin
                  discard_d   = 1'b0;
                  launch      = 1'b1;
                  launch_go   = pend_q;
                  launch_line = pend_line_q;
               end else begin
                  wr_en = 1'b1;
                  if (last_word) begin
                     state_d          = DONE;
                     mem_req_d        = 1'b0;
                     valid_d[wr_bank] = 1'b1;
                  end else begin
                     word_d     = word_q + WORD_AW'(1);
                     mem_addr_d = mem_addr_q + ADDR_W'(1);
                  end
               end
            end
         end
         default: begin
            if (frame_evt) begin
               launch      = 1'b1;
               launch_go   = start_req;
               launch_line = start_line;
            end
         end
      endcase

      if (launch) begin
         word_d = '0;
         if (launch_go) begin
            state_d    = REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = line_addr(fb_base, launch_line);
         end else begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      end
   end

   line_buffer #(
      .WORDS   (WORDS_PER_ROW),
      .WORD_AW (WORD_AW)
   ) u_line_buffer (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_bank (wr_bank),
      .wr_word (word_q),
      .wr_data (mem_data),
      .rd_bank (rd_bank_d),
      .rd_word (x_pos[9:5]),
      .rd_data (lb_rd_data)
   );

   // Display uses the post-swap bank so the first pixel of a line is correct.
   always_comb begin
      bit_idx = 4'd15 - x_pos[4:1];
      if (blank) begin
         rgb_d = '0;
      end else if (!valid_d[rd_bank_d] || (32'(x_pos[9:5]) >= WORDS_PER_ROW)) begin
         rgb_d = bg;
      end else begin
         rgb_d = lb_rd_data[bit_idx] ? fg : bg;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         word_q       <= '0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
         discard_q    <= 1'b0;
         pend_q       <= 1'b0;
         pend_line_q  <= '0;
         underrun_q   <= 1'b0;
         phys_line_q  <= '0;
         blank_prev_q <= 1'b0;
         rd_bank_q    <= 1'b0;
         valid_q      <= 2'b00;
         rgb_q        <= '0;
         hsync_q      <= 1'b0;
         vsync_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         word_q       <= word_d;
         mem_req_q    <= mem_req_d;
         mem_addr_q   <= mem_addr_d;
         discard_q    <= discard_d;
         pend_q       <= pend_d;
         pend_line_q  <= pend_line_d;
         underrun_q   <= underrun_d;
         phys_line_q  <= phys_line_d;
         blank_prev_q <= blank;
         rd_bank_q    <= rd_bank_d;
         valid_q      <= valid_d;
         rgb_q        <= rgb_d;
         hsync_q      <= hsync;
         vsync_q      <= vsync;
      end
   end

   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;
   assign rgb      = rgb_q;
   assign hsync_o  = hsync_q;
   assign vsync_o  = vsync_q;
   assign underrun = underrun_q;
endmodule

// File: tb/tb_pixel_fetch.sv
// Directed bench for pixel_fetch: reset, line fetch, pixel expansion, underrun,
// end-of-frame fetch suppression and vsync priority.
`timescale 1ns/1ps
module tb_pixel_fetch;
   import vga_pkg::*;

   logic        clk = 1'b0;
   logic        reset, blank, hsync, vsync, vsync_pulse;
   logic [9:0]  x_pos;
   logic [15:0] fb_base;
   logic [5:0]  fg, bg;
   logic        mem_req, mem_ack;
   logic [15:0] mem_addr, mem_data;
   logic [5:0]  rgb;
   logic        hsync_o, vsync_o, underrun;

   always #5 clk = ~clk;

   pixel_fetch dut (
      .clk         (clk),
      .reset       (reset),
      .x_pos       (x_pos),
      .blank       (blank),
      .hsync       (hsync),
      .vsync       (vsync),
      .vsync_pulse (vsync_pulse),
      .fb_base     (fb_base),
      .fg          (fg),
      .bg          (bg),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_data    (mem_data),
      .rgb         (rgb),
      .hsync_o     (hsync_o),
      .vsync_o     (vsync_o),
      .underrun    (underrun)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   bit          ack_en = 1'b0;
   bit          log_print = 1'b0;
   logic [15:0] log_addr [$];
   logic        first_req;
   logic [15:0] first_addr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Framebuffer contents: line 0 = 8000 0001 0000..., every later line all ones.
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      if (a == 16'h1000) return 16'h8000;
      if (a == 16'h1001) return 16'h0001;
      if (a < 16'h1019)  return 16'h0000;
      return 16'hFFFF;
   endfunction

   function automatic logic [5:0] exp_pix(input int lline, input int x, input bit vexp);
      logic [15:0] w;
      if (!vexp) return bg;
      w = mem_word(16'(32'h1000 + lline * 25 + (x >> 5)));
      return w[15 - ((x >> 1) & 15)] ? fg : bg;
   endfunction

   // Memory model: acks one cycle after it sees a request, one word per two cycles.
   initial begin
      mem_ack  = 1'b0;
      mem_data = 16'h0000;
      forever begin
         @(posedge clk);
         #2;
         if (mem_ack) begin
            mem_ack = 1'b0;
         end else if (ack_en && mem_req) begin
            mem_ack  = 1'b1;
            mem_data = mem_word(mem_addr);
            log_addr.push_back(mem_addr);
            if (log_print) $display("txn addr=0x%04h data=0x%04h", mem_addr, mem_data);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic vis_line(input int lline, input bit vexp, input bit en_ack);
      for (int x = 0; x < 64; x++) begin
         blank = 1'b0;
         x_pos = 10'(x);
         step();
         if (x == 0) begin
            first_req  = mem_req;
            first_addr = mem_addr;
            if (en_ack) ack_en = 1'b1;
         end
         check($sformatf("pix_l%0d_x%0d", lline, x), 32'(rgb), 32'(exp_pix(lline, x, vexp)));
      end
      blank = 1'b1;
      x_pos = '0;
      step();
      step();
   endtask

   initial begin
      int          idx0;
      int          gaps;
      int          nlog;
      logic        rb;
      logic [4:0]  hs_pat;
      logic [4:0]  vs_pat;

      reset = 1'b1; blank = 1'b1; hsync = 1'b1; vsync = 1'b1; vsync_pulse = 1'b0;
      x_pos = '0; fb_base = 16'h1000; fg = 6'h3F; bg = 6'h00;
      step(); step();
      check("rst_mem_req", 32'(mem_req), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_rgb", 32'(rgb), 0);
      check("rst_hsync_o", 32'(hsync_o), 0);
      check("rst_vsync_o", 32'(vsync_o), 0);
      check("rst_underrun", 32'(underrun), 0);
      check("rst_state", 32'(dut.state_q), 32'(IDLE));
      check("rst_phys_line", 32'(dut.phys_line_q), 0);
      check("rst_valid", 32'(dut.valid_q), 0);
      check("rst_rd_bank", 32'(dut.rd_bank_q), 0);
      reset = 1'b0; hsync = 1'b0; vsync = 1'b0;
      step();

      // Reset in the middle of a stalled fetch that already flagged an underrun.
      vsync_pulse = 1'b1; step(); vsync_pulse = 1'b0; step();
      check("stall_req", 32'(mem_req), 1);
      check("stall_addr", 32'(mem_addr), 32'h1000);
      vsync_pulse = 1'b1; step(); vsync_pulse = 1'b0; step();
      check("stall_underrun", 32'(underrun), 1);
      check("stall_req_held", 32'(mem_req), 1);
      reset = 1'b1; step();
      check("midrst_mem_req", 32'(mem_req), 0);
      check("midrst_rgb", 32'(rgb), 0);
      check("midrst_underrun", 32'(underrun), 0);
      check("midrst_state", 32'(dut.state_q), 32'(IDLE));
      reset = 1'b0; step();

      // Fetch of logical line 0.
      log_addr.delete();
      ack_en = 1'b1; log_print = 1'b1;
      vsync_pulse = 1'b1; step(); vsync_pulse = 1'b0;
      for (int i = 0; i < 200 && dut.state_q != DONE; i++) step();
      check("fetch0_state", 32'(dut.state_q), 32'(DONE));
      check("fetch0_count", log_addr.size(), 25);
      gaps = 0;
      for (int i = 0; i < log_addr.size(); i++)
         if (log_addr[i] != 16'(32'h1000 + i)) gaps++;
      check("fetch0_addr_seq", gaps, 0);
      check("fetch0_req_low", 32'(mem_req), 0);
      check("fetch0_valid", 32'(dut.valid_q), 32'h2);
      check("fetch0_underrun", 32'(underrun), 0);

      // Line 0 on physical lines 0 and 1, line 1 on physical line 2.
      vis_line(0, 1'b1, 1'b0);
      check("swap0_req", 32'(first_req), 1);
      check("swap0_addr", 32'(first_addr), 32'h1019);
      vis_line(0, 1'b1, 1'b0);
      ack_en = 1'b0;
      vis_line(1, 1'b1, 1'b0);
      check("swap1_addr", 32'(first_addr), 32'h1032);
      vis_line(1, 1'b1, 1'b0);

      // Line 2 never completes: underrun, blank line, then line 3 proceeds.
      bg = 6'h2A;
      idx0 = log_addr.size();
      vis_line(2, 1'b0, 1'b1);
      check("urun_flag", 32'(underrun), 1);
      check("urun_discard_addr", 32'(log_addr[idx0]), 32'h1032);
      check("urun_next_addr", 32'(log_addr[idx0 + 1]), 32'h104B);
      check("urun_next_count", log_addr.size() - idx0, 26);
      check("urun_next_state", 32'(dut.state_q), 32'(DONE));
      vis_line(2, 1'b0, 1'b0);
      vis_line(3, 1'b1, 1'b0);
      check("urun_sticky", 32'(underrun), 1);

      // Blanking forces black; sync outputs are delayed one register.
      hs_pat = 5'b01101;
      vs_pat = 5'b00110;
      for (int i = 0; i < 5; i++) begin
         blank = 1'b1; x_pos = 10'd5;
         hsync = hs_pat[i]; vsync = vs_pat[i];
         step();
         hsync = ~hs_pat[i]; vsync = ~vs_pat[i];
         #1;
         check($sformatf("blank_rgb_%0d", i), 32'(rgb), 0);
         check($sformatf("hsync_dly_%0d", i), 32'(hsync_o), 32'(hs_pat[i]));
         check($sformatf("vsync_dly_%0d", i), 32'(vsync_o), 32'(vs_pat[i]));
      end
      hsync = 1'b0; vsync = 1'b0;
      step();

      // Run out the frame to physical line 598 with short unchecked lines.
      log_print = 1'b0;
      for (int p = 7; p < 598; p++) begin
         blank = 1'b0;
         for (int c = 0; c < 52; c++) step();
         blank = 1'b1;
         step(); step();
      end
      check("eof_phys_line", 32'(dut.phys_line_q), 598);
      check("eof_last_state", 32'(dut.state_q), 32'(DONE));
      check("eof_last_addr", 32'(log_addr[log_addr.size() - 1]), 32'h2D4B);
      nlog = log_addr.size();
      blank = 1'b0; step();
      check("eof_no_fetch_state", 32'(dut.state_q), 32'(IDLE));
      check("eof_no_fetch_req", 32'(mem_req), 0);
      step(); step(); step();
      check("eof_no_fetch_log", log_addr.size(), nlog);
      check("eof_phys_line_599", 32'(dut.phys_line_q), 599);

      // vsync_pulse coinciding with a swap edge wins.
      blank = 1'b1; step();
      blank = 1'b0; step();
      blank = 1'b1; step();
      rb = dut.rd_bank_q;
      vsync_pulse = 1'b1; blank = 1'b0; step();
      vsync_pulse = 1'b0;
      check("vprio_phys_line", 32'(dut.phys_line_q), 0);
      check("vprio_valid", 32'(dut.valid_q), 0);
      check("vprio_rd_bank", 32'(dut.rd_bank_q), 32'(rb));
      check("vprio_state", 32'(dut.state_q), 32'(REQ));
      check("vprio_addr", 32'(mem_addr), 32'h1000);
      blank = 1'b1; step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
